// File: rtl/signed_scan_display.sv
// Signed value to multiplexed 7-segment display: valid/ready capture, sequential
// double-dabble to sign-magnitude BCD, then leading-zero blanked digit scan.
module signed_scan_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_value,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en,
  output logic              neg,
  output logic              ovf,
  output logic              busy
);
  localparam int NB = (WIDTH * 3) / 10 + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, COMMIT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [4*NB-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NB-1:0]   disp_bcd_q, disp_bcd_d;
  logic              disp_neg_q, disp_neg_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        cur_digit;
  int                top_k;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Index of the most significant nonzero BCD digit; zero counts as one digit.
  function automatic int msd(input logic [4*NB-1:0] b);
    int k;
    k = 0;
    for (int i = 0; i < NB; i++) begin
      if (b[4*i +: 4] != 4'd0) k = i;
      else k = k;
    end
    return k;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONVERT; else state_d = IDLE;
      CONVERT: if (cnt_q == CW'(WIDTH - 1)) state_d = COMMIT; else state_d = CONVERT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  // Conversion datapath and display register loads
  always_comb begin
    sign_d     = sign_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_ovf_d = disp_ovf_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                          bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_value[WIDTH-1];
          // Negating -2^(WIDTH-1) yields 2^(WIDTH-1) when read as unsigned.
          bin_d  = in_value[WIDTH-1] ? (~in_value + {{(WIDTH-1){1'b0}}, 1'b1}) : in_value;
          bcd_d  = '0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[4*NB-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
      COMMIT: begin
        disp_bcd_d = bcd_q;
        disp_neg_d = sign_q;
        disp_ovf_d = ((msd(bcd_q) + (sign_q ? 2 : 1)) > DIGITS);
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Conversion and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q     <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  // Scan prescaler and digit index; free-running regardless of FSM state
  always_comb begin
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IW'(DIGITS - 1)) idx_d = '0;
      else                          idx_d = idx_q + IW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
    end
  end

  // Scan registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Segment pattern for the currently enabled position
  always_comb begin
    top_k     = msd(disp_bcd_q);
    cur_digit = 4'd0;
    for (int i = 0; i < NB; i++) begin
      if (int'(idx_q) == i) cur_digit = disp_bcd_q[4*i +: 4];
      else                  cur_digit = cur_digit;
    end
    if (disp_ovf_q)                                seg = 7'b0001000;
    else if (int'(idx_q) <= top_k)                 seg = glyph(cur_digit);
    else if (int'(idx_q) == top_k + 1 && disp_neg_q) seg = 7'b1000000;
    else                                           seg = 7'b0000000;
  end

  // Digit enable and status outputs
  always_comb begin
    dig_en = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    neg    = disp_neg_q;
    ovf    = disp_ovf_q;
  end
endmodule
